// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, IDLE/RUN/PAUSE control and 1 Hz tick prescaler for the MM:SS stopwatch.
// Optional long-press clear on btn_startstop is enabled by defining STOPWATCH_LONGPRESS_CLEAR_EN.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYC = 50,
    parameter int TICK_DIV     = 5000,
    parameter int LONG_CYC     = 10000
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       btn_startstop,
    input  logic       btn_clear,
    output logic       run,
    output logic       tick,
    output logic       clear_pulse,
    output logic [1:0] state
);
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYC - 1);
    localparam logic [PW-1:0] PR_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;

    // Button vectors: bit 0 is startstop, bit 1 is clear.
    logic [1:0]         s1_q, s1_d, s2_q, s2_d, db_q, db_d, dly_q, dly_d, press;
    logic [1:0][DW-1:0] cnt_q, cnt_d;
    state_t             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               tick_q, tick_d, clear_pulse_q, clear_pulse_d;
    logic               long_clr, clr, wrap;

    // Synchronize raw buttons and accept a new level only after it has been stable long enough.
    always_comb begin
        s1_d  = {btn_clear, btn_startstop};
        s2_d  = s1_q;
        dly_d = db_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = (s2_q[i] != db_q[i] && cnt_q[i] != DB_MAX) ? cnt_q[i] + 1'b1 : '0;
            db_d[i]  = (s2_q[i] != db_q[i] && cnt_q[i] == DB_MAX) ? s2_q[i] : db_q[i];
        end
    end

    // Synchronizer, debounce and press-edge registers; buttons reset to the released level.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            s1_q  <= '1;
            s2_q  <= '1;
            db_q  <= '1;
            dly_q <= '1;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            db_q  <= db_d;
            dly_q <= dly_d;
            cnt_q <= cnt_d;
        end
    end

    assign press = dly_q & ~db_q;

`ifdef STOPWATCH_LONGPRESS_CLEAR_EN
    localparam int LW = $clog2(LONG_CYC + 1);
    localparam logic [LW-1:0] LP_FIRE = LW'(LONG_CYC - 1);
    localparam logic [LW-1:0] LP_SAT  = LW'(LONG_CYC);
    logic [LW-1:0] lp_q, lp_d;

    // Long-press timer saturates past the fire point so one hold clears only once.
    always_comb begin
        lp_d     = db_q[0] ? '0 : (lp_q == LP_SAT) ? lp_q : lp_q + 1'b1;
        long_clr = ~db_q[0] && (lp_q == LP_FIRE);
    end

    // Long-press timer register.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) lp_q <= '0;
        else        lp_q <= lp_d;
    end
`else
    assign long_clr = 1'b0;
`endif

    // Next state, prescaler and pulse outputs; clear overrides startstop and suppresses a pending tick.
    always_comb begin
        clr           = press[1] | long_clr;
        wrap          = presc_q == PR_MAX;
        state_d       = clr ? IDLE : !press[0] ? state_q : (state_q == RUN) ? PAUSE : RUN;
        presc_d       = (clr || state_q == IDLE) ? '0 : (state_d != RUN) ? presc_q : wrap ? '0 : presc_q + 1'b1;
        tick_d        = !clr && state_q != IDLE && state_d == RUN && wrap;
        clear_pulse_d = clr;
    end

    // Control FSM with registered tick and clear pulses.
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            presc_q       <= '0;
            tick_q        <= 1'b0;
            clear_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            tick_q        <= tick_d;
            clear_pulse_q <= clear_pulse_d;
        end
    end

    assign state       = state_q;
    assign run         = state_q == RUN;
    assign tick        = tick_q;
    assign clear_pulse = clear_pulse_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench for stopwatch_ctrl (DEBOUNCE_CYC=4, TICK_DIV=10, LONG_CYC=20).
module tb_stopwatch_ctrl;
    localparam int DEB = 4, DIV = 10, LONG = 20;

    logic       clkin = 1'b0, reset = 1'b1, btn_startstop = 1'b1, btn_clear = 1'b1;
    logic       run, tick, clear_pulse;
    logic [1:0] state;
    int         cyc = 0, checks = 0, errors = 0, t_entry = 0;
    bit         mon_en = 1'b0;

    typedef struct {logic [1:0] kind; int at;} ev_t;
    ev_t exp_q[$];

    stopwatch_ctrl #(.DEBOUNCE_CYC(DEB), .TICK_DIV(DIV), .LONG_CYC(LONG)) dut (
        .clkin(clkin), .reset(reset), .btn_startstop(btn_startstop), .btn_clear(btn_clear),
        .run(run), .tick(tick), .clear_pulse(clear_pulse), .state(state)
    );

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    // Event kinds: 2'b01 tick, 2'b10 clear_pulse; each expected event carries the edge index it follows.
    always @(negedge clkin) begin : mon
        ev_t e;
        if (mon_en) begin
            if (tick || clear_pulse) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got kind=%b at cyc=%0d want none", {clear_pulse, tick}, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({clear_pulse, tick} !== e.kind || cyc != e.at) begin
                        errors++;
                        $display("FAIL event got kind=%b at cyc=%0d want kind=%b at cyc=%0d", {clear_pulse, tick}, cyc, e.kind, e.at);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].at <= cyc) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL missed_event got none at cyc=%0d want kind=%b at cyc=%0d", cyc, e.kind, e.at);
            end
        end
    end

    task automatic push(input logic [1:0] k, input int at);
        ev_t e;
        e.kind = k;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic step_to(input int c);
        if (c > cyc) step(c - cyc);
    endtask

    task automatic test_reset();
        step(2);
        #3 reset = 1'b0;
        #1;
        checks += 4;
        if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b want=00", state); end
        if (run !== 1'b0) begin errors++; $display("FAIL reset_run got=%b want=0", run); end
        if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", tick); end
        if (clear_pulse !== 1'b0) begin errors++; $display("FAIL reset_clear got=%b want=0", clear_pulse); end
        step(2);
        reset  = 1'b1;
        mon_en = 1'b1;
        step(50);
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL idle_state got=%b want=00", state); end
    endtask

    task automatic test_glitch();
        btn_startstop = 1'b0;
        step(3);
        btn_startstop = 1'b1;
        step(12);
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL glitch_state got=%b want=00", state); end
    endtask

    task automatic test_start();
        int p;
        p       = cyc;
        t_entry = p + 7;
        push(2'b01, t_entry + DIV);
        push(2'b01, t_entry + 2 * DIV);
        btn_startstop = 1'b0;
        step(5);
        btn_startstop = 1'b1;
        step(1);
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL start_early got=%b want=00", state); end
        step(1);
        checks += 2;
        if (state !== 2'b01) begin errors++; $display("FAIL start_state got=%b want=01", state); end
        if (run !== 1'b1) begin errors++; $display("FAIL start_run got=%b want=1", run); end
        step_to(t_entry + 2 * DIV);
    endtask

    task automatic test_pause_resume();
        int s, r;
        s = cyc;
        btn_startstop = 1'b0;
        step(5);
        btn_startstop = 1'b1;
        step(2);
        checks += 2;
        if (state !== 2'b10) begin errors++; $display("FAIL pause_state got=%b want=10", state); end
        if (run !== 1'b0) begin errors++; $display("FAIL pause_run got=%b want=0", run); end
        step_to(s + 25);
        checks++;
        if (state !== 2'b10) begin errors++; $display("FAIL pause_hold got=%b want=10", state); end
        r = cyc;
        push(2'b01, r + 10);
        push(2'b01, r + 20);
        btn_startstop = 1'b0;
        step(5);
        btn_startstop = 1'b1;
        step(2);
        checks++;
        if (state !== 2'b01) begin errors++; $display("FAIL resume_state got=%b want=01", state); end
        step_to(r + 23);
    endtask

    task automatic test_clear(input bit both);
        int c;
        c = cyc;
        push(2'b10, c + 7);
        btn_clear = 1'b0;
        if (both) btn_startstop = 1'b0;
        step(5);
        btn_clear     = 1'b1;
        btn_startstop = 1'b1;
        step(2);
        checks += 2;
        if (state !== 2'b00) begin errors++; $display("FAIL clear_state both=%0d got=%b want=00", both, state); end
        if (run !== 1'b0) begin errors++; $display("FAIL clear_run both=%0d got=%b want=0", both, run); end
        step(30);
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL clear_after both=%0d got=%b want=00", both, state); end
    endtask

    task automatic test_longpress();
        int p;
        p = cyc;
        push(2'b01, p + 17);
`ifdef STOPWATCH_LONGPRESS_CLEAR_EN
        push(2'b10, p + 26);
`else
        push(2'b01, p + 27);
        push(2'b01, p + 37);
`endif
        btn_startstop = 1'b0;
        step(7);
        checks++;
        if (state !== 2'b01) begin errors++; $display("FAIL long_press_state got=%b want=01", state); end
        step_to(p + 26);
`ifdef STOPWATCH_LONGPRESS_CLEAR_EN
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL long_clear_state got=%b want=00", state); end
        step_to(p + 30);
        btn_startstop = 1'b1;
        step_to(p + 45);
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL long_after got=%b want=00", state); end
`else
        checks++;
        if (state !== 2'b01) begin errors++; $display("FAIL long_hold_state got=%b want=01", state); end
        step_to(p + 30);
        btn_startstop = 1'b1;
        step_to(p + 38);
        checks++;
        if (state !== 2'b01) begin errors++; $display("FAIL long_after got=%b want=01", state); end
        mon_en = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_start();
        test_pause_resume();
        test_clear(1'b1);
        test_clear(1'b0);
        test_start();
        test_clear(1'b0);
        test_longpress();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL pending_events got=%0d want=0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Upstream control stage for the 4-digit MM:SS stopwatch counter. It conditions the raw active-low push-buttons, runs an IDLE/RUN/PAUSE state machine, and generates a one-cycle 1 Hz `tick` enable while running. The seconds/minutes digit counter consumes `tick` and `clear_pulse`; this block owns all button timing and prescaling. Clocked from the 5 kHz PLL output.

Parameters:
- DEBOUNCE_CYC, 50, consecutive stable cycles required to accept a button level change (10 ms at 5 kHz).
- TICK_DIV, 5000, clock cycles per tick (1 s at 5 kHz).
- LONG_CYC, 10000, long-press length in cycles; used only with the optional feature.

Ports:
- clkin, input, 1, 5 kHz clock, single clock domain.
- reset, input, 1, asynchronous, active-low reset.
- btn_startstop, input, 1, raw button, active-low, asynchronous to clkin.
- btn_clear, input, 1, raw button, active-low, asynchronous to clkin.
- run, output, 1, high while state is RUN.
- tick, output, 1, one-cycle pulse per elapsed second while in RUN.
- clear_pulse, output, 1, one-cycle pulse commanding the digit counter to zero.
- state, output, 2, 00 IDLE, 01 RUN, 10 PAUSE; 11 is never produced.

Behaviour:
- Reset (reset=0, asynchronous, active-low): applies immediately, independent of clkin.
  - Synchronizers and debounced levels are set to 1 (released).
  - Debounce counters and prescaler are set to 0.
  - state=IDLE; run=0, tick=0, clear_pulse=0.
- Synchronizer: 2-flop per button, s1 then s2.
- Debounce, per button:
  - If s2 != db, increment cnt. Otherwise cnt=0.
  - When cnt==DEBOUNCE_CYC-1 and s2 != db: db<=s2, cnt<=0.
  - A glitch shorter than DEBOUNCE_CYC cycles leaves db unchanged.
- Press detect:
  - db_q is db delayed one cycle.
  - press = db_q & ~db, high for exactly one cycle per accepted press.
  - Release produces no event.
- Latency: raw falling level sampled at edge 1 gives db=0 at edge DEBOUNCE_CYC+2, press high during the following cycle, and state update at edge DEBOUNCE_CYC+3.
- FSM, evaluated on press events:
  - IDLE: startstop → RUN.
  - RUN: startstop → PAUSE.
  - PAUSE: startstop → RUN.
  - Any state: clear → IDLE, with clear_pulse=1 for exactly the cycle of the transition edge (registered).
  - Simultaneous clear and startstop in the same cycle: clear wins; startstop is discarded.
  - Clear in IDLE still emits clear_pulse.
- Prescaler (width clog2(TICK_DIV)):
  - In RUN: counts 0..TICK_DIV-1.
  - At TICK_DIV-1: tick=1 (registered, one cycle) and wrap to 0.
  - In PAUSE: holds its value, so a partial second is preserved across pause/resume.
  - In IDLE, or on clear: forced to 0.
  - First tick after IDLE→RUN occurs exactly TICK_DIV cycles after entering RUN.
  - A clear issued on the same cycle the prescaler would wrap suppresses that tick.
- Outputs:
  - run and state decode directly from the state register (no extra latency).
  - tick and clear_pulse are never high in the same cycle.
- Held button: produces one press only; a new press requires a debounced release and then a new press.

Optional Feature:
- Macro: STOPWATCH_LONGPRESS_CLEAR_EN.
- When defined:
  - A long-press counter runs while the debounced btn_startstop is 0.
  - When it reaches LONG_CYC-1, the block performs the clear action (→ IDLE, clear_pulse one cycle) once per hold.
  - The short-press toggle still occurs at press time. A long press therefore toggles first, then clears.
  - The counter resets on release.
- When undefined: no long-press logic is present, LONG_CYC is unused, and only btn_clear clears.

Test Plan:
Use DEBOUNCE_CYC=4, TICK_DIV=10, LONG_CYC=20 for simulation.
1. Reset then idle: reset=0 mid-cycle, then released → state=00, run=0, tick=0, clear_pulse=0 immediately; no tick over 50 cycles.
2. Start: btn_startstop low from edge 1 → state=01 at edge 7; tick pulses at 10 cycles after RUN entry, then every 10 cycles thereafter.
3. Glitch: btn_startstop low for 3 cycles → state stays 00; low for 4+ cycles → RUN.
4. Pause/resume: press at prescaler=6 → PAUSE, count frozen at 6, no tick; press again → RUN, next tick 3 cycles after resume edge (counts 7, 8, 9).
5. Clear priority: both buttons pressed on the same cycle while in RUN → state=00, exactly one clear_pulse, prescaler=0, no subsequent tick.
6. STOPWATCH_LONGPRESS_CLEAR_EN defined: from IDLE hold btn_startstop 30 cycles → RUN at press, then IDLE with one clear_pulse 20 cycles after debounced press; undefined build stays RUN.
